// File: rtl/i2c_pkg.sv
// i2c_pkg: shared constants for the I2C master core.
//   - command codes presented on the cmd port
//   - FSM state encodings (plain localparams, 4 bits)
//   - ACK/NACK levels of the ninth (acknowledge) bit
package i2c_pkg;

  localparam logic [2:0] CMD_START   = 3'd0;
  localparam logic [2:0] CMD_WR      = 3'd1;
  localparam logic [2:0] CMD_RD      = 3'd2;
  localparam logic [2:0] CMD_STOP    = 3'd3;
  localparam logic [2:0] CMD_RESTART = 3'd4;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_START1 = 4'd1;
  localparam logic [3:0] ST_START2 = 4'd2;
  localparam logic [3:0] ST_HOLD   = 4'd3;
  localparam logic [3:0] ST_DATA1  = 4'd4;
  localparam logic [3:0] ST_DATA2  = 4'd5;
  localparam logic [3:0] ST_DATA3  = 4'd6;
  localparam logic [3:0] ST_DATA4  = 4'd7;
  localparam logic [3:0] ST_RS1    = 4'd8;
  localparam logic [3:0] ST_RS2    = 4'd9;
  localparam logic [3:0] ST_RS3    = 4'd10;
  localparam logic [3:0] ST_STOP1  = 4'd11;
  localparam logic [3:0] ST_STOP2  = 4'd12;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_phase_timer.sv
// i2c_phase_timer: quarter/half bit phase timer for the I2C master.
// Optional feature macro: CLK_STRETCH_EN (slave clock stretching).
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_run           count while high; counter forced to 0 when low
//   i_half          terminal count is a half period (2*(dvsr+1) cycles)
//   i_stretch       current phase has SCL released (stretch-sensitive)
//   i_scl_in        SCL pad level
//   i_dvsr          quarter phase length minus one
//   o_done          last cycle of the current phase
module i2c_phase_timer #(
  parameter int DVSR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_run,
  input  logic              i_half,
  input  logic              i_stretch,
  input  logic              i_scl_in,
  input  logic [DVSR_W-1:0] i_dvsr,
  output logic              o_done
);

  logic [DVSR_W:0] r_cnt;
  logic [DVSR_W:0] w_term;
  logic            w_hold;

  // Half period ends at 2*dvsr+1, i.e. {dvsr,1}.
  assign w_term = i_half ? {i_dvsr, 1'b1} : {1'b0, i_dvsr};

`ifdef CLK_STRETCH_EN
  // A slave holding SCL low keeps the high phase from starting.
  assign w_hold = i_stretch & ~i_scl_in;
`else
  logic w_unused;
  assign w_hold   = 1'b0;
  assign w_unused = i_stretch ^ i_scl_in;
`endif

  assign o_done = i_run & ~w_hold & (r_cnt == w_term);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                        r_cnt <= '0;
    else if (!i_run || w_hold || o_done) r_cnt <= '0;
    else                                 r_cnt <= r_cnt + (DVSR_W+1)'(1);
  end

endmodule

// File: rtl/i2c_master_core.sv
// i2c_master_core: byte-level I2C master with START/WR/RD/STOP/RESTART
// commands and per-byte ACK/NACK selection on reads.
// Optional feature macro: CLK_STRETCH_EN (see i2c_phase_timer).
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_wr_i2c, i_cmd  command strobe and code (taken only when o_ready=1)
//   i_din            WR: byte to send; RD: bit0=1 sends NACK
//   i_dvsr           quarter-bit phase length minus one
//   i_sda_in/i_scl_in pad levels
//   o_dout, o_ack    last received byte and its acknowledge bit
//   o_ready          high in IDLE and HOLD
//   o_done_tick      last cycle of each WR/RD byte
//   o_sda_oe/o_scl_oe open-drain pull-low enables
module i2c_master_core
  import i2c_pkg::*;
#(
  parameter int DVSR_W = 16,
  parameter int CMD_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_i2c,
  input  logic [CMD_W-1:0]  i_cmd,
  input  logic [7:0]        i_din,
  input  logic [DVSR_W-1:0] i_dvsr,
  input  logic              i_sda_in,
  input  logic              i_scl_in,
  output logic [7:0]        o_dout,
  output logic              o_ack,
  output logic              o_ready,
  output logic              o_done_tick,
  output logic              o_sda_oe,
  output logic              o_scl_oe
);

  logic [3:0] r_state;
  logic [8:0] r_tx;
  logic [8:0] r_rx;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_dout;
  logic       r_ack;

  logic w_sda_oe, w_scl_oe, w_run, w_half, w_stretch;
  logic w_tdone, w_accept, w_last_bit;

  i2c_phase_timer #(.DVSR_W(DVSR_W)) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_run     (w_run),
    .i_half    (w_half),
    .i_stretch (w_stretch),
    .i_scl_in  (i_scl_in),
    .i_dvsr    (i_dvsr),
    .o_done    (w_tdone)
  );

  // Pad enables and timer controls decoded from the state.
  always_comb begin
    w_sda_oe  = 1'b0;
    w_scl_oe  = 1'b0;
    w_run     = 1'b1;
    w_half    = 1'b0;
    w_stretch = 1'b0;
    case (r_state)
      ST_IDLE:   w_run = 1'b0;
      ST_START1: begin w_sda_oe = 1'b1; w_half = 1'b1; end
      ST_START2: begin w_sda_oe = 1'b1; w_scl_oe = 1'b1; w_half = 1'b1; end
      ST_HOLD:   begin w_sda_oe = 1'b1; w_scl_oe = 1'b1; w_run = 1'b0; end
      ST_DATA1:  begin w_sda_oe = ~r_tx[8]; w_scl_oe = 1'b1; end
      ST_DATA2:  begin w_sda_oe = ~r_tx[8]; w_stretch = 1'b1; end
      ST_DATA3:  w_sda_oe = ~r_tx[8];
      ST_DATA4:  begin w_sda_oe = ~r_tx[8]; w_scl_oe = 1'b1; end
      ST_RS1:    w_scl_oe = 1'b1;
      ST_RS2:    w_stretch = 1'b1;
      ST_RS3:    begin w_sda_oe = 1'b1; w_half = 1'b1; end
      ST_STOP1:  begin w_sda_oe = 1'b1; w_half = 1'b1; w_stretch = 1'b1; end
      ST_STOP2:  w_half = 1'b1;
      default:   w_run = 1'b0;
    endcase
  end

  assign o_ready     = (r_state == ST_IDLE) || (r_state == ST_HOLD);
  assign w_accept    = i_wr_i2c & o_ready;
  assign w_last_bit  = (r_bit_cnt == 4'd8);
  assign o_done_tick = (r_state == ST_DATA4) & w_tdone & w_last_bit;
  assign o_sda_oe    = w_sda_oe;
  assign o_scl_oe    = w_scl_oe;
  assign o_dout      = r_dout;
  assign o_ack       = r_ack;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_tx      <= '0;
      r_rx      <= '0;
      r_bit_cnt <= '0;
      r_dout    <= '0;
      r_ack     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE:
          if (w_accept && i_cmd == CMD_W'(CMD_START)) r_state <= ST_START1;
        ST_START1: if (w_tdone) r_state <= ST_START2;
        ST_START2: if (w_tdone) r_state <= ST_HOLD;
        ST_HOLD:
          if (w_accept) begin
            case (i_cmd)
              CMD_W'(CMD_WR): begin
                // ACK slot released so the slave can answer
                r_tx      <= {i_din, I2C_NACK};
                r_bit_cnt <= '0;
                r_state   <= ST_DATA1;
              end
              CMD_W'(CMD_RD): begin
                // data bits released; our ACK/NACK goes in the last slot
                r_tx      <= {8'hFF, i_din[0]};
                r_bit_cnt <= '0;
                r_state   <= ST_DATA1;
              end
              CMD_W'(CMD_STOP):    r_state <= ST_STOP1;
              CMD_W'(CMD_START),
              CMD_W'(CMD_RESTART): r_state <= ST_RS1;
              default:             r_state <= ST_HOLD;
            endcase
          end
        ST_DATA1: if (w_tdone) r_state <= ST_DATA2;
        ST_DATA2:
          if (w_tdone) begin
            r_rx    <= {r_rx[7:0], i_sda_in};
            r_state <= ST_DATA3;
          end
        ST_DATA3: if (w_tdone) r_state <= ST_DATA4;
        ST_DATA4:
          if (w_tdone) begin
            if (w_last_bit) begin
              r_bit_cnt <= '0;
              r_dout    <= r_rx[8:1];
              r_ack     <= r_rx[0];
              r_state   <= ST_HOLD;
            end else begin
              r_tx      <= {r_tx[7:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 4'd1;
              r_state   <= ST_DATA1;
            end
          end
        ST_RS1:   if (w_tdone) r_state <= ST_RS2;
        ST_RS2:   if (w_tdone) r_state <= ST_RS3;
        ST_RS3:   if (w_tdone) r_state <= ST_START2;
        ST_STOP1: if (w_tdone) r_state <= ST_STOP2;
        ST_STOP2: if (w_tdone) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_core.sv
// Bench for i2c_master_core: an open-drain bus model with a byte-level
// slave, a bus monitor (SCL-rise samples, START/STOP detection), a table
// of directed byte transfers, random transfers checked against a
// wired-AND protocol model, and hand-written corner sequences.
module tb_i2c_master_core;
  import i2c_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_wr_i2c;
  logic [2:0]  i_cmd;
  logic [7:0]  i_din;
  logic [15:0] i_dvsr;
  logic        i_sda_in, i_scl_in;
  logic [7:0]  o_dout;
  logic        o_ack, o_ready, o_done_tick, o_sda_oe, o_scl_oe;

  i2c_master_core #(.DVSR_W(16), .CMD_W(3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_i2c(i_wr_i2c), .i_cmd(i_cmd),
    .i_din(i_din), .i_dvsr(i_dvsr), .i_sda_in(i_sda_in), .i_scl_in(i_scl_in),
    .o_dout(o_dout), .o_ack(o_ack), .o_ready(o_ready),
    .o_done_tick(o_done_tick), .o_sda_oe(o_sda_oe), .o_scl_oe(o_scl_oe)
  );

  always #5 i_clk = ~i_clk;

  int total = 0, bad = 0;
  int cyc = 0, acc_cyc = 0;
  always @(posedge i_clk) cyc++;

  // Bus: wired-AND of master, slave and clock-stretching slave.
  logic       stretch_low = 1'b0;
  logic       slv_en = 1'b0;
  logic [8:0] slv_pat = 9'h1FF;
  int         slv_base = 0, slv_k;
  logic       slv_low;
  int         fall_cnt = 0, starts = 0, stops = 0, done_cnt = 0;
  logic       rise_q[$];
  logic       p_scl = 1'b1, p_sda = 1'b1, m_scl, m_sda;

  // Slave presents bit k of its pattern after the k-th SCL fall of the byte.
  always_comb begin
    slv_k   = fall_cnt - slv_base;
    slv_low = 1'b0;
    if (slv_en && slv_k >= 0 && slv_k < 9) slv_low = ~slv_pat[8 - slv_k];
  end
  assign i_sda_in = ~o_sda_oe & ~slv_low;
  assign i_scl_in = ~o_scl_oe & ~stretch_low;

  always @(negedge i_clk) begin
    m_scl = ~o_scl_oe & ~stretch_low;
    m_sda = ~o_sda_oe & ~slv_low;
    if (!p_scl && m_scl) rise_q.push_back(m_sda);
    if (p_scl && !m_scl) fall_cnt++;
    if (p_scl && m_scl && p_sda && !m_sda) starts++;
    if (p_scl && m_scl && !p_sda && m_sda) stops++;
    if (o_done_tick) done_cnt++;
    p_scl = m_scl;
    p_sda = m_sda;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Protocol model: what the line carries for one byte is the AND of what
  // each side leaves released.
  function automatic logic [8:0] bus_model(input logic rd, input logic [7:0] din,
                                           input logic [7:0] sbyte, input logic sack);
    logic [8:0] m, s;
    m = rd ? {8'hFF, din[0]} : {din, 1'b1};
    s = rd ? {sbyte, 1'b1}   : {8'hFF, sack};
    return m & s;
  endfunction

  task automatic issue(input logic [2:0] c, input logic [7:0] d);
    @(negedge i_clk); #1;
    i_cmd = c; i_din = d; i_wr_i2c = 1'b1;
    @(posedge i_clk); #1;
    acc_cyc = cyc;
    @(negedge i_clk); #1;
    i_wr_i2c = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!o_ready && n < 500) begin
      @(negedge i_clk); #1;
      n++;
    end
    chk(name, 32'(o_ready), 32'd1);
  endtask

  // One byte in HOLD; latency counts from the strobe cycle to done_tick.
  task automatic run_byte(input logic rd, input logic [7:0] din, input logic [7:0] sbyte,
                          input logic sack, input int dv, input bit inject, input bit stretch,
                          output logic [8:0] bits, output int lat, output int nd);
    int base, post, st_state, st_left;
    i_dvsr   = 16'(dv);
    slv_pat  = rd ? {sbyte, 1'b1} : {8'hFF, sack};
    slv_base = fall_cnt;
    slv_en   = 1'b1;
    base     = rise_q.size();
    issue(rd ? CMD_RD : CMD_WR, din);
    lat = -1; nd = 0; post = 0; st_state = 0; st_left = 0;
    for (int i = 0; i < 4000 && post < 4; i++) begin
      if (inject && i == 20) begin i_wr_i2c = 1'b1; i_cmd = CMD_STOP; i_din = ~din; end
      if (inject && i == 21) i_wr_i2c = 1'b0;
      if (stretch) begin
        if (i == 0) stretch_low = 1'b1;
        else if (st_state == 0 && !o_scl_oe) begin st_state = 1; st_left = 10; end
        else if (st_state == 1) begin
          st_left--;
          if (st_left == 0) begin stretch_low = 1'b0; st_state = 2; end
        end
      end
      if (o_done_tick) begin
        nd++;
        if (lat < 0) lat = cyc - acc_cyc + 1;
      end
      if (lat >= 0) post++;
      @(negedge i_clk); #1;
    end
    stretch_low = 1'b0;
    if (lat < 0) chk("byte_timeout", 32'd0, 32'd1);
    for (int k = 0; k < 9; k++)
      bits[8-k] = (base + k < rise_q.size()) ? rise_q[base + k] : 1'bx;
  endtask

  typedef struct {
    logic       rd;
    logic [7:0] din;
    logic [7:0] sbyte;
    logic       sack;
    int         dvsr;
    logic [8:0] exp_bits;
    logic [7:0] exp_dout;
    logic       exp_ack;
    int         exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic byte_check(input string tag, input logic rd, input logic [7:0] din,
                            input logic [7:0] sbyte, input logic sack, input int dv,
                            input bit inject);
    logic [8:0] bits, eb;
    int lat, nd;
    eb = bus_model(rd, din, sbyte, sack);
    run_byte(rd, din, sbyte, sack, dv, inject, 1'b0, bits, lat, nd);
    chk({tag, "_bits"}, 32'(bits), 32'(eb));
    chk({tag, "_dout"}, 32'(o_dout), 32'(eb[8:1]));
    chk({tag, "_ack"},  32'(o_ack), 32'(eb[0]));
    chk({tag, "_lat"},  32'(lat), 32'(36 * (dv + 1)));
    chk({tag, "_ndone"}, 32'(nd), 32'd1);
  endtask

  initial begin
    logic [8:0] bits;
    int lat, nd, s0, p0, d0, n;

    vecs[0] = '{1'b0, 8'hA5, 8'h00, 1'b0, 4, 9'h14A, 8'hA5, 1'b0, 180};
    vecs[1] = '{1'b1, 8'h01, 8'h3C, 1'b1, 4, 9'h079, 8'h3C, 1'b1, 180};
    vecs[2] = '{1'b1, 8'h00, 8'hC3, 1'b1, 4, 9'h186, 8'hC3, 1'b0, 180};
    vecs[3] = '{1'b0, 8'h5A, 8'h00, 1'b1, 0, 9'h0B5, 8'h5A, 1'b1, 36};
    vecs[4] = '{1'b1, 8'hFF, 8'h00, 1'b1, 1, 9'h001, 8'h00, 1'b1, 72};

    i_rst_n = 1'b0; i_wr_i2c = 1'b0; i_cmd = '0; i_din = '0; i_dvsr = 16'd4;
    repeat (3) @(negedge i_clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_sda_oe", 32'(o_sda_oe), 32'd0);
    chk("rst_scl_oe", 32'(o_scl_oe), 32'd0);
    chk("rst_done", 32'(o_done_tick), 32'd0);
    chk("rst_dout", 32'(o_dout), 32'd0);
    chk("rst_ack", 32'(o_ack), 32'd0);
    i_rst_n = 1'b1;

    // START into HOLD
    s0 = starts;
    issue(CMD_START, 8'h00);
    wait_ready("start_ready");
    chk("start_cond", 32'(starts - s0), 32'd1);
    chk("hold_scl_oe", 32'(o_scl_oe), 32'd1);
    chk("hold_sda_oe", 32'(o_sda_oe), 32'd1);

    foreach (vecs[i]) begin
      run_byte(vecs[i].rd, vecs[i].din, vecs[i].sbyte, vecs[i].sack, vecs[i].dvsr,
               1'b0, 1'b0, bits, lat, nd);
      chk($sformatf("vec%0d_bits", i), 32'(bits), 32'(vecs[i].exp_bits));
      chk($sformatf("vec%0d_dout", i), 32'(o_dout), 32'(vecs[i].exp_dout));
      chk($sformatf("vec%0d_ack", i), 32'(o_ack), 32'(vecs[i].exp_ack));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_ndone", i), 32'(nd), 32'd1);
      chk($sformatf("vec%0d_ready", i), 32'(o_ready), 32'd1);
    end

    // strobe in the middle of a byte must not disturb it
    byte_check("midbyte", 1'b0, 8'h3C, 8'h00, 1'b0, 2, 1'b1);

    for (int r = 0; r < 12; r++)
      byte_check($sformatf("rnd%0d", r), 1'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom), int'($urandom_range(0, 3)), 1'b0);

    // WR, RESTART, WR, STOP
    byte_check("rs_w50", 1'b0, 8'h50, 8'h00, 1'b0, 4, 1'b0);
    s0 = starts;
    issue(CMD_RESTART, 8'h00);
    wait_ready("rs_ready");
    chk("rs_start_cond", 32'(starts - s0), 32'd1);
    byte_check("rs_w51", 1'b0, 8'h51, 8'h00, 1'b0, 4, 1'b0);
    p0 = stops;
    issue(CMD_STOP, 8'h00);
    wait_ready("stop_ready");
    chk("stop_cond", 32'(stops - p0), 32'd1);
    chk("stop_sda_oe", 32'(o_sda_oe), 32'd0);
    chk("stop_scl_oe", 32'(o_scl_oe), 32'd0);

    // WR in IDLE is ignored
    d0 = done_cnt;
    issue(CMD_WR, 8'h77);
    repeat (60) @(negedge i_clk);
    #1;
    chk("idle_wr_done", 32'(done_cnt - d0), 32'd0);
    chk("idle_wr_ready", 32'(o_ready), 32'd1);
    chk("idle_wr_scl", 32'(o_scl_oe), 32'd0);
    chk("idle_wr_sda", 32'(o_sda_oe), 32'd0);

    // clock stretching on the first bit of a byte
    issue(CMD_START, 8'h00);
    wait_ready("st_start_ready");
    run_byte(1'b0, 8'hA5, 8'h00, 1'b0, 4, 1'b0, 1'b1, bits, lat, nd);
`ifdef CLK_STRETCH_EN
    chk("stretch_lat", 32'(lat), 32'd190);
`else
    chk("stretch_lat", 32'(lat), 32'd180);
`endif
    chk("stretch_ndone", 32'(nd), 32'd1);
    byte_check("pre_rst_rd", 1'b1, 8'h01, 8'h96, 1'b1, 4, 1'b0);

    // async reset in DATA3
    i_dvsr = 16'd4;
    issue(CMD_WR, 8'h5A);
    n = 0;
    while (o_scl_oe && n < 100) begin @(negedge i_clk); #1; n++; end
    chk("rst_reach_data2", 32'(o_scl_oe), 32'd0);
    repeat (7) @(negedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("arst_sda_oe", 32'(o_sda_oe), 32'd0);
    chk("arst_scl_oe", 32'(o_scl_oe), 32'd0);
    chk("arst_ready", 32'(o_ready), 32'd1);
    chk("arst_dout", 32'(o_dout), 32'd0);
    chk("arst_done", 32'(o_done_tick), 32'd0);
    repeat (3) @(negedge i_clk);
    #1;
    i_rst_n = 1'b1;
    issue(CMD_START, 8'h00);
    wait_ready("post_rst_ready");
    byte_check("post_rst", 1'b0, 8'hA5, 8'h00, 1'b0, 4, 1'b0);
    issue(CMD_STOP, 8'h00);
    wait_ready("post_rst_stop");
    chk("post_rst_scl", 32'(o_scl_oe), 32'd0);
    chk("post_rst_sda", 32'(o_sda_oe), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
